// File: rtl/sync_fifo_thresh.sv
// sync_fifo_thresh: parametrised synchronous FIFO with selectable read mode
// (registered or first-word-fall-through), programmable almost-full and
// almost-empty thresholds, live fill count, sticky overflow/underflow flags
// and a synchronous flush. Any depth >= 2 is supported; pointers wrap
// explicitly at FIFO_DEPTH-1 rather than relying on binary rollover.
module sync_fifo_thresh #(
    parameter int FIFO_WIDTH = 36,
    parameter int FIFO_DEPTH = 10,
    parameter int FWFT       = 0,
    parameter int AF_THRESH  = 8,
    parameter int AE_THRESH  = 2,
    localparam int CW        = $clog2(FIFO_DEPTH + 1)
) (
    input  logic                  clk,
    input  logic                  clr_n,
    input  logic                  flush_in,
    input  logic                  we_in,
    input  logic                  rd_in,
    input  logic [FIFO_WIDTH-1:0] data_in,
    output logic [FIFO_WIDTH-1:0] data_out,
    output logic                  empty_out,
    output logic                  full_out,
    output logic                  almost_empty_out,
    output logic                  almost_full_out,
    output logic [CW-1:0]         count_out,
    output logic                  overflow_out,
    output logic                  underflow_out
);

    localparam int PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;

    logic [FIFO_WIDTH-1:0] fifo_block_r [FIFO_DEPTH-1:0];
    logic [PW-1:0]         wr_ptr_reg, wr_ptr_next;
    logic [PW-1:0]         rd_ptr_reg, rd_ptr_next;
    logic [CW-1:0]         count_reg, count_next;
    logic                  overflow_reg, underflow_reg;
    logic                  empty, full;
    logic                  wr_acc, rd_acc;
    logic [FIFO_DEPTH-1:0] wr_sel;

    // Status is decoded from the registered count only.
    assign empty            = (count_reg == '0);
    assign full             = (count_reg == CW'(FIFO_DEPTH));
    assign empty_out        = empty;
    assign full_out         = full;
    assign almost_empty_out = (count_reg <= CW'(AE_THRESH));
    assign almost_full_out  = (count_reg >= CW'(AF_THRESH));
    assign count_out        = count_reg;
    assign overflow_out     = overflow_reg;
    assign underflow_out    = underflow_reg;

    // A read while full frees a slot, so a write on the same edge is accepted.
    // Flush wins over both requests.
    assign rd_acc = rd_in && !empty && !flush_in;
    assign wr_acc = we_in && (!full || rd_in) && !flush_in;

    // One-hot write select per storage entry.
    genvar gi;
    generate
        for (gi = 0; gi < FIFO_DEPTH; gi++) begin : g_wr_sel
            assign wr_sel[gi] = wr_acc && (wr_ptr_reg == PW'(gi));
        end
    endgenerate

    // Next-state for pointers and fill count, wrapping at FIFO_DEPTH-1.
    always_comb begin
        wr_ptr_next = wr_ptr_reg;
        rd_ptr_next = rd_ptr_reg;
        count_next  = count_reg;
        if (wr_acc)
            wr_ptr_next = (wr_ptr_reg == PW'(FIFO_DEPTH - 1)) ? '0 : wr_ptr_reg + PW'(1);
        if (rd_acc)
            rd_ptr_next = (rd_ptr_reg == PW'(FIFO_DEPTH - 1)) ? '0 : rd_ptr_reg + PW'(1);
        if (wr_acc && !rd_acc)
            count_next = count_reg + CW'(1);
        else if (rd_acc && !wr_acc)
            count_next = count_reg - CW'(1);
    end

    // Storage array: cleared only by reset, flush leaves contents intact.
    always_ff @(posedge clk or negedge clr_n) begin
        if (!clr_n) begin
            for (int i = 0; i < FIFO_DEPTH; i++)
                fifo_block_r[i] <= '0;
        end else begin
            for (int i = 0; i < FIFO_DEPTH; i++)
                if (wr_sel[i])
                    fifo_block_r[i] <= data_in;
        end
    end

    // Pointers, count and sticky error flags; flush returns them to idle.
    always_ff @(posedge clk or negedge clr_n) begin
        if (!clr_n) begin
            wr_ptr_reg    <= '0;
            rd_ptr_reg    <= '0;
            count_reg     <= '0;
            overflow_reg  <= 1'b0;
            underflow_reg <= 1'b0;
        end else if (flush_in) begin
            wr_ptr_reg    <= '0;
            rd_ptr_reg    <= '0;
            count_reg     <= '0;
            overflow_reg  <= 1'b0;
            underflow_reg <= 1'b0;
        end else begin
            wr_ptr_reg <= wr_ptr_next;
            rd_ptr_reg <= rd_ptr_next;
            count_reg  <= count_next;
            if (we_in && full && !rd_in)
                overflow_reg <= 1'b1;
            if (rd_in && empty && !we_in)
                underflow_reg <= 1'b1;
        end
    end

    generate
        if (FWFT != 0) begin : g_fwft
            // Head word is presented directly; zero while nothing is stored.
            assign data_out = empty ? '0 : fifo_block_r[rd_ptr_reg];
        end else begin : g_regrd
            logic [FIFO_WIDTH-1:0] dout_reg;

            // Output register loads the head word on each accepted read.
            always_ff @(posedge clk or negedge clr_n) begin
                if (!clr_n)
                    dout_reg <= '0;
                else if (flush_in)
                    dout_reg <= '0;
                else if (rd_acc)
                    dout_reg <= fifo_block_r[rd_ptr_reg];
            end

            assign data_out = dout_reg;
        end
    endgenerate

endmodule

// File: tb/tb_sync_fifo_thresh.sv
// Directed bench for sync_fifo_thresh: a registered-read instance (a_*)
// and a first-word-fall-through instance (b_*) sharing clock and reset.
module tb_sync_fifo_thresh;

    localparam int W  = 36;
    localparam int CW = 4;

    logic clk = 1'b0;
    logic clr_n = 1'b0;

    logic          a_flush, a_we, a_rd;
    logic [W-1:0]  a_din, a_dout;
    logic          a_empty, a_full, a_ae, a_af, a_ov, a_un;
    logic [CW-1:0] a_cnt;

    logic          b_flush, b_we, b_rd;
    logic [W-1:0]  b_din, b_dout;
    logic          b_empty, b_full, b_ae, b_af, b_ov, b_un;
    logic [CW-1:0] b_cnt;

    int checks = 0;
    int passed = 0;

    sync_fifo_thresh #(.FIFO_WIDTH(W), .FIFO_DEPTH(10), .FWFT(0),
                       .AF_THRESH(8), .AE_THRESH(2)) dut_a (
        .clk(clk), .clr_n(clr_n), .flush_in(a_flush), .we_in(a_we), .rd_in(a_rd),
        .data_in(a_din), .data_out(a_dout), .empty_out(a_empty), .full_out(a_full),
        .almost_empty_out(a_ae), .almost_full_out(a_af), .count_out(a_cnt),
        .overflow_out(a_ov), .underflow_out(a_un));

    sync_fifo_thresh #(.FIFO_WIDTH(W), .FIFO_DEPTH(10), .FWFT(1),
                       .AF_THRESH(8), .AE_THRESH(2)) dut_b (
        .clk(clk), .clr_n(clr_n), .flush_in(b_flush), .we_in(b_we), .rd_in(b_rd),
        .data_in(b_din), .data_out(b_dout), .empty_out(b_empty), .full_out(b_full),
        .almost_empty_out(b_ae), .almost_full_out(b_af), .count_out(b_cnt),
        .overflow_out(b_ov), .underflow_out(b_un));

    always #5 clk = ~clk;

    // Advance one clock; sample point is 1 time unit after the rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic a_idle();
        a_flush = 1'b0; a_we = 1'b0; a_rd = 1'b0; a_din = '0;
    endtask

    task automatic test_reset();
        clr_n = 1'b0;
        for (int c = 0; c < 2; c++) begin
            a_flush = 1'($urandom); a_we = 1'($urandom); a_rd = 1'($urandom);
            a_din = {4'($urandom), 32'($urandom)};
            b_flush = 1'($urandom); b_we = 1'($urandom); b_rd = 1'($urandom);
            b_din = {4'($urandom), 32'($urandom)};
            tick();
        end
        checks++; if (a_dout !== '0) $display("FAIL reset_a_dout got %h want 0", a_dout); else passed++;
        checks++; if ({a_empty, a_full, a_ae, a_af, a_ov, a_un} !== 6'b101000)
            $display("FAIL reset_a_flags got %b want 101000", {a_empty, a_full, a_ae, a_af, a_ov, a_un}); else passed++;
        checks++; if (a_cnt !== 4'd0) $display("FAIL reset_a_count got %0d want 0", a_cnt); else passed++;
        checks++; if (b_dout !== '0) $display("FAIL reset_b_dout got %h want 0", b_dout); else passed++;
        checks++; if ({b_empty, b_full, b_ae, b_af, b_ov, b_un, b_cnt} !== {6'b101000, 4'd0})
            $display("FAIL reset_b_state got %b want 1010000000", {b_empty, b_full, b_ae, b_af, b_ov, b_un, b_cnt}); else passed++;
        a_idle();
        b_flush = 1'b0; b_we = 1'b0; b_rd = 1'b0; b_din = '0;
        clr_n = 1'b1;
        tick();
        $display("reset: released, count_a=%0d count_b=%0d", a_cnt, b_cnt);
    endtask

    task automatic test_fill();
        for (int i = 0; i < 10; i++) begin
            a_we = 1'b1; a_din = W'(i);
            tick();
            checks++; if (a_cnt !== 4'(i + 1)) $display("FAIL fill_count got %0d want %0d", a_cnt, i + 1); else passed++;
            checks++; if ({a_ae, a_af, a_full} !== {(i + 1) <= 2, (i + 1) >= 8, (i + 1) == 10})
                $display("FAIL fill_flags n=%0d got ae/af/full=%b want %b", i + 1, {a_ae, a_af, a_full},
                         {(i + 1) <= 2, (i + 1) >= 8, (i + 1) == 10}); else passed++;
            $display("fill: wrote %0d count=%0d", i, a_cnt);
        end
        a_din = W'(36'hBEEF);
        tick();
        checks++; if (a_ov !== 1'b1) $display("FAIL overflow_set got %b want 1", a_ov); else passed++;
        checks++; if (a_cnt !== 4'd10) $display("FAIL overflow_count got %0d want 10", a_cnt); else passed++;
        $display("fill: 11th write refused, overflow=%b", a_ov);
        a_idle();
    endtask

    task automatic test_drain();
        for (int i = 0; i < 10; i++) begin
            a_rd = 1'b1;
            tick();
            checks++; if (a_dout !== W'(i)) $display("FAIL drain_data got %h want %h", a_dout, W'(i)); else passed++;
            checks++; if (a_empty !== (i == 9)) $display("FAIL drain_empty got %b want %b", a_empty, i == 9); else passed++;
            $display("drain: read %h count=%0d", a_dout, a_cnt);
        end
        tick();
        checks++; if (a_un !== 1'b1) $display("FAIL underflow_set got %b want 1", a_un); else passed++;
        checks++; if (a_dout !== W'(9)) $display("FAIL underflow_hold got %h want 9", a_dout); else passed++;
        $display("drain: 11th read refused, underflow=%b", a_un);
        a_idle();
    endtask

    task automatic test_simultaneous();
        a_flush = 1'b1;
        tick();
        a_idle();
        checks++; if ({a_ov, a_un, a_cnt, a_dout} !== {2'b00, 4'd0, 36'h0})
            $display("FAIL flush_clear got ov=%b un=%b cnt=%0d dout=%h want 0", a_ov, a_un, a_cnt, a_dout); else passed++;
        a_we = 1'b1; a_rd = 1'b1; a_din = W'(36'hBEEF);
        tick();
        checks++; if (a_cnt !== 4'd1) $display("FAIL simul_empty_count got %0d want 1", a_cnt); else passed++;
        checks++; if (a_un !== 1'b0) $display("FAIL simul_empty_underflow got %b want 0", a_un); else passed++;
        checks++; if (a_dout !== '0) $display("FAIL simul_empty_dout got %h want 0", a_dout); else passed++;
        $display("simul: we/rd on empty count=%0d", a_cnt);
        a_rd = 1'b0;
        for (int i = 1; i < 10; i++) begin
            a_din = W'(36'h100 + i);
            tick();
        end
        checks++; if (a_full !== 1'b1) $display("FAIL refill_full got %b want 1", a_full); else passed++;
        a_rd = 1'b1; a_din = W'(36'h55);
        tick();
        checks++; if (a_cnt !== 4'd10) $display("FAIL simul_full_count got %0d want 10", a_cnt); else passed++;
        checks++; if (a_dout !== W'(36'hBEEF)) $display("FAIL simul_full_dout got %h want beef", a_dout); else passed++;
        checks++; if (a_ov !== 1'b0) $display("FAIL simul_full_overflow got %b want 0", a_ov); else passed++;
        $display("simul: we/rd on full dout=%h count=%0d", a_dout, a_cnt);
        a_we = 1'b0;
        for (int i = 1; i <= 10; i++) begin
            logic [W-1:0] exp;
            exp = (i == 10) ? W'(36'h55) : W'(36'h100 + i);
            tick();
            checks++; if (a_dout !== exp) $display("FAIL wrap_data got %h want %h", a_dout, exp); else passed++;
            $display("wrap: read %h", a_dout);
        end
        a_idle();
        checks++; if (a_empty !== 1'b1) $display("FAIL wrap_empty got %b want 1", a_empty); else passed++;
    endtask

    task automatic test_fwft();
        b_we = 1'b1; b_din = W'(36'hA5);
        tick();
        b_we = 1'b0;
        checks++; if (b_dout !== W'(36'hA5)) $display("FAIL fwft_first got %h want a5", b_dout); else passed++;
        checks++; if (b_empty !== 1'b0) $display("FAIL fwft_not_empty got %b want 0", b_empty); else passed++;
        $display("fwft: wrote a5 dout=%h", b_dout);
        b_we = 1'b1; b_din = W'(36'h5A);
        tick();
        b_we = 1'b0;
        checks++; if (b_dout !== W'(36'hA5)) $display("FAIL fwft_head_hold got %h want a5", b_dout); else passed++;
        b_rd = 1'b1;
        tick();
        checks++; if (b_dout !== W'(36'h5A)) $display("FAIL fwft_next got %h want 5a", b_dout); else passed++;
        $display("fwft: read dout=%h", b_dout);
        tick();
        b_rd = 1'b0;
        checks++; if ({b_dout, b_empty} !== {36'h0, 1'b1})
            $display("FAIL fwft_empty got dout=%h empty=%b want 0/1", b_dout, b_empty); else passed++;
        checks++; if (b_un !== 1'b0) $display("FAIL fwft_underflow got %b want 0", b_un); else passed++;
        $display("fwft: drained dout=%h empty=%b", b_dout, b_empty);
    endtask

    task automatic test_flush();
        a_we = 1'b1;
        for (int i = 0; i < 11; i++) begin
            a_din = W'(36'h200 + i);
            tick();
        end
        a_we = 1'b0; a_rd = 1'b1;
        for (int i = 0; i < 5; i++) tick();
        a_rd = 1'b0;
        checks++; if ({a_cnt, a_ov} !== {4'd5, 1'b1})
            $display("FAIL preflush got cnt=%0d ov=%b want 5/1", a_cnt, a_ov); else passed++;
        a_flush = 1'b1; a_we = 1'b1; a_din = W'(36'h77);
        tick();
        a_idle();
        checks++; if ({a_cnt, a_empty, a_ov} !== {4'd0, 1'b1, 1'b0})
            $display("FAIL flush got cnt=%0d empty=%b ov=%b want 0/1/0", a_cnt, a_empty, a_ov); else passed++;
        $display("flush: count=%0d overflow=%b", a_cnt, a_ov);
        a_we = 1'b1; a_din = W'(36'h33);
        tick();
        a_we = 1'b0; a_rd = 1'b1;
        tick();
        a_rd = 1'b0;
        checks++; if (a_dout !== W'(36'h33)) $display("FAIL flush_dropped got %h want 33", a_dout); else passed++;
        checks++; if (a_empty !== 1'b1) $display("FAIL flush_after_empty got %b want 1", a_empty); else passed++;
        $display("flush: post-flush read %h", a_dout);
    endtask

    task automatic test_async_reset();
        a_we = 1'b1;
        for (int i = 0; i < 3; i++) begin
            a_din = W'(36'h11 * (i + 1));
            tick();
        end
        a_we = 1'b0; a_rd = 1'b1;
        tick();
        a_rd = 1'b0;
        checks++; if ({a_dout, a_cnt} !== {36'h11, 4'd2})
            $display("FAIL prereset got dout=%h cnt=%0d want 11/2", a_dout, a_cnt); else passed++;
        #2;
        clr_n = 1'b0;
        #1;
        checks++; if ({a_dout, a_cnt, a_empty} !== {36'h0, 4'd0, 1'b1})
            $display("FAIL async_clear got dout=%h cnt=%0d empty=%b want 0/0/1", a_dout, a_cnt, a_empty); else passed++;
        a_we = 1'b1; a_din = W'(36'h99);
        tick();
        checks++; if (a_cnt !== 4'd0) $display("FAIL reset_blocks_write got %0d want 0", a_cnt); else passed++;
        a_idle();
        clr_n = 1'b1;
        tick();
        checks++; if ({a_cnt, a_empty, a_dout} !== {4'd0, 1'b1, 36'h0})
            $display("FAIL post_release got cnt=%0d empty=%b dout=%h", a_cnt, a_empty, a_dout); else passed++;
        $display("async_reset: count=%0d dout=%h", a_cnt, a_dout);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "timeout");
    end

    initial begin
        a_idle();
        b_flush = 1'b0; b_we = 1'b0; b_rd = 1'b0; b_din = '0;
        #1;
        test_reset();
        test_fill();
        test_drain();
        test_simultaneous();
        test_fwft();
        test_flush();
        test_async_reset();
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule

// File: doc/sync_fifo_thresh.md
# sync_fifo_thresh

Parametrised synchronous FIFO that supersedes the fixed-behaviour sync FIFO in the VGA controller buffering path (e.g. pixel/line data between the memory fetch logic and the pixel output stage). It adds:
- selectable read mode: registered read or first-word-fall-through (FWFT);
- programmable almost-full and almost-empty thresholds;
- a live fill-level count;
- sticky overflow and underflow error flags;
- a synchronous flush.

It supports non-power-of-two depths.

## Interface
- FIFO_WIDTH, 36, data word width in bits (≥1)
- FIFO_DEPTH, 10, number of entries (≥2, any integer)
- FWFT, 0, 0 = registered read (data 1 cycle after accepted read), 1 = first-word-fall-through
- AF_THRESH, 8, almost_full_out asserted when count ≥ AF_THRESH (1..FIFO_DEPTH)
- AE_THRESH, 2, almost_empty_out asserted when count ≤ AE_THRESH (0..FIFO_DEPTH-1)
- CW (localparam), $clog2(FIFO_DEPTH+1), count width

Ports:
- clk  in  1  clock
- clr_n  in  1  reset, asynchronous, active-low
- flush_in  in  1  synchronous flush, active-high
- we_in  in  1  write request
- rd_in  in  1  read request
- data_in  in  FIFO_WIDTH  write data
- data_out  out  FIFO_WIDTH  read data
- empty_out  out  1  count == 0
- full_out  out  1  count == FIFO_DEPTH
- almost_empty_out  out  1  count ≤ AE_THRESH
- almost_full_out  out  1  count ≥ AF_THRESH
- count_out  out  CW  current fill level
- overflow_out  out  1  sticky: write refused
- underflow_out  out  1  sticky: read refused

## Operation
- Storage: register array fifo_block_r[FIFO_DEPTH-1:0], write pointer, read pointer and count, all registered.
- Pointers run 0..FIFO_DEPTH-1 and wrap to 0 after FIFO_DEPTH-1.
- Read accepted: rd_in && !empty.
- Write accepted: we_in && (!full || rd_in).
- Simultaneous we_in and rd_in:
  - when empty: write only; count becomes 1; no underflow.
  - when full: read and write both accepted; count unchanged; both pointers advance.
  - otherwise: both accepted; count unchanged.
- Count rules: +1 on write-only, -1 on read-only.
- overflow_out set when we_in && full && !rd_in; the write is dropped and memory is unchanged.
- underflow_out set when rd_in && empty && !we_in. It is not set when empty with we_in && rd_in.
- Both error flags stay set until clr_n or flush_in.
- FWFT=0: data_out is a register loaded with fifo_block_r[rd_ptr] on an accepted read; otherwise it holds.
- FWFT=1: data_out = fifo_block_r[rd_ptr] combinationally when !empty, all-zero when empty. An accepted read advances to the next word.
- flush_in: zeroes pointers, count, overflow_out, underflow_out and (FWFT=0) the data_out register. It has priority over we_in/rd_in in the same cycle. Memory contents are not cleared.
- clr_n low: async clear of all of the above plus every fifo_block_r entry to 0.
- All status outputs (empty, full, almost_*, count) are combinational decodes of the registered count only; no input-to-status paths.

## Timing
- Reset values:
  - data_out = 0
  - empty_out = 1
  - full_out = 0
  - almost_empty_out = 1
  - almost_full_out = (AF_THRESH == 0, never by constraint) i.e. 0
  - count_out = 0
  - overflow_out = 0
  - underflow_out = 0
- Write latency: data sampled at the posedge. Status is valid immediately after that edge.
- FWFT=1: the first word appears on data_out in the cycle after the write edge into an empty FIFO.
- FWFT=0 read latency: 1 cycle; data_out is valid after the edge that accepts the read.
- Reset mid-operation: takes effect immediately and asynchronously. Release is synchronous to the next posedge; no write/read is accepted on an edge where clr_n is low.
- Sticky flags assert on the same edge as the offending request.

## Test plan
- Reset: hold clr_n low 2 cycles with random inputs → all outputs at reset values and all 10 fifo_block_r entries = 0.
- Fill (FWFT=0, defaults): write 0..9 → count_out 1..10; almost_empty_out deasserts at count 3; almost_full_out asserts at count 8; full_out at 10. An 11th write of 0xBEEF with rd_in=0 → overflow_out=1, count 10, memory unchanged.
- Drain (FWFT=0): 10 reads → data_out = 0..9, each one cycle after its accepting edge; empty_out=1 after the 10th. An 11th read → underflow_out=1, data_out holds 9.
- Simultaneous ops:
  - empty + we/rd with data 0xBEEF → count 1, underflow_out stays 0, data_out unchanged.
  - Refill to full, then we/rd with data 0x55 → count stays 10, data_out = oldest word, pointers wrap past index 9.
- FWFT=1 instance: write 0xA5 into empty → data_out=0xA5 next cycle with no rd_in. Write 0x5A then read → data_out=0x5A. Read → data_out=0, empty_out=1.
- Flush/reset mid-stream: with 5 entries, overflow set, flush_in with we_in=1 → count 0, empty_out=1, overflow_out=0, write dropped. Repeat with clr_n pulse mid-cycle → immediate async clear.
